// File: rtl/add_accumulator_seq_pkg.sv
// Shared types and defaults for the add_accumulator_seq block.
// Optional feature macro: ADD_ACC_SATURATE_EN (saturating accumulator on overflow).
package add_accumulator_seq_pkg;

  localparam int unsigned DefWidth        = 4;
  localparam int unsigned DefCntWidth     = 4;
  localparam int unsigned DefSettleCycles = 5;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccept = 2'd1,
    StSettle = 2'd2,
    StDone   = 2'd3
  } state_e;

  // Saturation limits for the default 4-bit width.
  localparam logic [DefWidth-1:0] SatMax = 4'b0111;
  localparam logic [DefWidth-1:0] SatMin = 4'b1000;

  // Settle counter width; a one-cycle window still needs one bit.
  function automatic int unsigned timer_width(int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/add_accumulator_seq_if.sv
// Operand stream, result stream, control and adder-side signals of add_accumulator_seq.
interface add_accumulator_seq_if
  import add_accumulator_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned CNT_WIDTH = DefCntWidth
) ();

  logic                 start;
  logic [CNT_WIDTH-1:0] num_terms;
  logic                 busy;

  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;

  logic [WIDTH-1:0]     adder_a;
  logic [WIDTH-1:0]     adder_b;
  logic [WIDTH-1:0]     adder_sum;
  logic                 adder_carryout;
  logic                 adder_overflow;

  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic                 out_overflow;
  logic [CNT_WIDTH-1:0] out_carry_count;

  // Environment side: drives control, operands, adder results and result acceptance.
  modport master (
    output start, num_terms, in_valid, in_data, adder_sum, adder_carryout, adder_overflow,
           out_ready,
    input  busy, in_ready, adder_a, adder_b, out_valid, out_result, out_overflow,
           out_carry_count
  );

  // Sequencer side.
  modport slave (
    input  start, num_terms, in_valid, in_data, adder_sum, adder_carryout, adder_overflow,
           out_ready,
    output busy, in_ready, adder_a, adder_b, out_valid, out_result, out_overflow,
           out_carry_count
  );

endinterface

// File: rtl/add_settle_timer.sv
// Loadable down-counter timing the settle window of gate-delayed structural logic.
// done is high while the count is zero; load takes priority over counting.
module add_settle_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             en,
  output logic             done
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: reload, or count down to zero and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/add_accumulator_seq.sv
// Sequencer/accumulator around an external gate-delayed two's-complement ripple adder.
// Each operand is registered onto the adder with the running total, the outputs are
// captured after a fixed settle window, and after num_terms operands the total is
// presented with a sticky overflow flag and a saturating carry count.
// Optional feature macro: ADD_ACC_SATURATE_EN (clamp the total on overflow).
module add_accumulator_seq
  import add_accumulator_seq_pkg::*;
#(
  parameter int unsigned WIDTH         = DefWidth,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned CNT_WIDTH     = DefCntWidth
) (
  input logic                 clk,
  input logic                 rst_n,
  add_accumulator_seq_if.slave bus
);

  localparam int unsigned         TimerW     = timer_width(SETTLE_CYCLES);
  localparam logic [TimerW-1:0]   SettleLoad = TimerW'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CNT_WIDTH-1:0] terms_q, terms_d;
  logic [CNT_WIDTH-1:0] carry_q, carry_d;
  logic                 ovf_q, ovf_d;

  logic accept;
  logic settling;
  logic settle_done;

  assign accept   = (state_q == StAccept) && bus.in_valid;
  assign settling = (state_q == StSettle);

  add_settle_timer #(
    .Width (TimerW)
  ) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_value (SettleLoad),
    .en         (settling),
    .done       (settle_done)
  );

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    terms_d = terms_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          carry_d = '0;
          terms_d = bus.num_terms;
          state_d = (bus.num_terms == '0) ? StDone : StAccept;
        end
      end

      StAccept: begin
        if (bus.in_valid) begin
          a_d     = acc_q;
          b_d     = bus.in_data;
          state_d = StSettle;
        end
      end

      StSettle: begin
        if (settle_done) begin
`ifdef ADD_ACC_SATURATE_EN
          // Clamp toward the sign of the running total that overflowed.
          if (bus.adder_overflow) begin
            acc_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            acc_d = bus.adder_sum;
          end
`else
          acc_d = bus.adder_sum;
`endif
          ovf_d = ovf_q | bus.adder_overflow;
          if (bus.adder_carryout && (carry_q != '1)) begin
            carry_d = carry_q + 1'b1;
          end
          terms_d = terms_q - 1'b1;
          state_d = (terms_q == CNT_WIDTH'(1)) ? StDone : StAccept;
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      terms_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      terms_q <= terms_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy            = (state_q != StIdle);
  assign bus.in_ready        = (state_q == StAccept);
  assign bus.out_valid       = (state_q == StDone);
  assign bus.adder_a         = a_q;
  assign bus.adder_b         = b_q;
  // The accumulator is cleared on start, so it doubles as the held result.
  assign bus.out_result      = acc_q;
  assign bus.out_overflow    = ovf_q;
  assign bus.out_carry_count = carry_q;

endmodule

// File: tb/tb_add_accumulator_seq.sv
// Directed bench for add_accumulator_seq with a behavioural 4-bit adder.
module tb_add_accumulator_seq;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  add_accumulator_seq_if #(.WIDTH(4), .CNT_WIDTH(4)) bus ();

  add_accumulator_seq #(
    .WIDTH         (4),
    .SETTLE_CYCLES (5),
    .CNT_WIDTH     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference ripple adder: 5-bit unsigned sum for carry, sign rule for overflow.
  logic [4:0] full_sum;
  assign full_sum           = {1'b0, bus.adder_a} + {1'b0, bus.adder_b};
  assign bus.adder_sum      = full_sum[3:0];
  assign bus.adder_carryout = full_sum[4];
  assign bus.adder_overflow = (bus.adder_a[3] == bus.adder_b[3]) &&
                              (full_sum[3] != bus.adder_a[3]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Start an accumulation with in_valid held high and measure clocks from the start edge
  // to the first cycle with out_valid.
  task automatic run_acc(input logic [3:0] n, input logic [3:0] o0, input logic [3:0] o1,
                         input logic [3:0] o2, input int exp_lat);
    logic [3:0] ops [3];
    int         idx;
    int         lat;
    logic       hs;
    ops[0] = o0;
    ops[1] = o1;
    ops[2] = o2;
    idx    = 0;
    lat    = -1;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_terms = n;
    bus.in_valid  = (n != 4'd0);
    bus.in_data   = o0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    if (bus.out_valid) lat = 0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      hs = bus.in_ready & bus.in_valid;
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        if (idx < 3) bus.in_data = ops[idx];
      end
      if (bus.out_valid) lat = c;
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {19'd0, bus.busy, bus.in_ready, bus.out_valid, bus.adder_a, bus.adder_b,
                bus.out_result, bus.out_overflow, bus.out_carry_count}, 32'd0);
  endtask

  initial begin
    logic [3:0] sat_exp;
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.num_terms = 4'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;

    // 1 + 2 + 3.
    run_acc(4'd3, 4'h1, 4'h2, 4'h3, 18);
    check("t1_result", 32'(bus.out_result), 32'h6);
    check("t1_ovf", 32'(bus.out_overflow), 32'd0);
    check("t1_carry", 32'(bus.out_carry_count), 32'd0);
    consume();

    // 7 + 1 overflows positive.
`ifdef ADD_ACC_SATURATE_EN
    sat_exp = 4'b0111;
`else
    sat_exp = 4'b1000;
`endif
    run_acc(4'd2, 4'h7, 4'h1, 4'h0, 12);
    check("t2_result", 32'(bus.out_result), 32'(sat_exp));
    check("t2_ovf", 32'(bus.out_overflow), 32'd1);
    check("t2_carry", 32'(bus.out_carry_count), 32'd0);
    consume();

    // -1 + -1 carries without overflow.
    run_acc(4'd2, 4'hf, 4'hf, 4'h0, 12);
    check("t3_result", 32'(bus.out_result), 32'he);
    check("t3_ovf", 32'(bus.out_overflow), 32'd0);
    check("t3_carry", 32'(bus.out_carry_count), 32'd1);

    // Result held and start ignored while out_ready stays low.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_terms = 4'd3;
    repeat (2) @(negedge clk);
    check("t3_hold_result", 32'(bus.out_result), 32'he);
    check("t3_hold_carry", 32'(bus.out_carry_count), 32'd1);
    bus.start = 1'b0;
    consume();

    // Zero terms: immediate result, stable under backpressure.
    run_acc(4'd0, 4'h0, 4'h0, 4'h0, 0);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_terms = 4'd2;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 check("t4_hold", {19'd0, bus.busy, bus.in_ready, bus.out_valid, bus.out_result,
                           bus.out_overflow, bus.out_carry_count}, {19'd0, 3'b101, 9'd0});
    end
    bus.start = 1'b0;
    consume();

    // Reset in the middle of settling term 2.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_terms = 4'd3;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1 bus.in_data = 4'h1;
    repeat (8) @(posedge clk);
    #1 check("t5_mid_operands", {24'd0, bus.adder_a, bus.adder_b}, 32'h71);
    check("t5_mid_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t5_async_reset");
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_acc(4'd1, 4'h5, 4'h0, 4'h0, 6);
    check("t6_result", 32'(bus.out_result), 32'h5);
    check("t6_ovf", 32'(bus.out_overflow), 32'd0);
    check("t6_carry", 32'(bus.out_carry_count), 32'd0);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/add_accumulator_seq.md
Name: add_accumulator_seq

Overview:
Sequencer and accumulator wrapped around the team's 4-bit two's-complement ripple adder.
- Accepts a stream of signed 4-bit operands over a valid/ready handshake.
- Drives each operand and the running total into the adder.
- Waits a fixed settle window for the gate-delayed adder outputs, then captures sum, carryout and overflow.
- After N terms, presents the final total with a sticky overflow flag and a carry count.

Parameters:
WIDTH, 4, operand/accumulator width; must equal adder width
SETTLE_CYCLES, 5, clocks between driving adder inputs and capturing outputs; must be >= 1 and SETTLE_CYCLES x clock period > worst-case adder delay
CNT_WIDTH, 4, width of num_terms and the carry counter

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a new accumulation; sampled only in IDLE
num_terms  in  CNT_WIDTH  number of operands to sum; sampled with start
busy  out  1  high in every state except IDLE
in_valid  in  1  operand valid
in_data  in  WIDTH  signed operand
in_ready  out  1  high only in ACCEPT
adder_a  out  WIDTH  to adder operand a (running total); registered
adder_b  out  WIDTH  to adder operand b (current operand); registered
adder_sum  in  WIDTH  from adder sum
adder_carryout  in  1  from adder carryout
adder_overflow  in  1  from adder overflow
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  final signed total
out_overflow  out  1  sticky OR of adder_overflow across all terms
out_carry_count  out  CNT_WIDTH  number of terms producing carryout; saturates at all-ones

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 (busy, in_ready, out_valid, adder_a, adder_b, out_result, out_overflow, out_carry_count); accumulator, counters and sticky flags cleared.
- States: IDLE, ACCEPT, SETTLE, DONE.
- IDLE, start=1:
  - num_terms=0: go to DONE with result 0 and flags 0.
  - Otherwise: load terms_left=num_terms, clear acc, sticky overflow and carry count; go to ACCEPT.
  - start in any other state is ignored.
- ACCEPT: in_ready=1. On in_valid&in_ready, on the same edge:
  - adder_b<=in_data and adder_a<=acc.
  - settle_cnt<=SETTLE_CYCLES-1.
  - Go to SETTLE.
  - No handshake: stay in ACCEPT indefinitely.
- SETTLE: in_ready=0; adder_a/adder_b held stable. Decrement settle_cnt each clock. On the edge where settle_cnt==0:
  - acc<=adder_sum.
  - ovf_sticky<=ovf_sticky|adder_overflow.
  - carry_cnt<=carry_cnt+adder_carryout, saturating.
  - terms_left<=terms_left-1.
  - If terms_left==1: go to DONE, else go to ACCEPT.
- Per-term latency: 1 accept clock + SETTLE_CYCLES clocks. Back-to-back operands are accepted every SETTLE_CYCLES+1 clocks. Adder inputs never change mid-settle.
- DONE: out_valid=1; out_result/out_overflow/out_carry_count held stable while out_ready=0. On out_valid&out_ready, go to IDLE; out_valid deasserts the next cycle. Result registers keep their values until the next start.
- Arithmetic: wrap-around two's complement. Overflow is taken only from the adder; the block does no recomputation.
- Reset mid-operation: any state returns immediately to the reset values. Any partial sum is discarded; out_valid is never produced for it.

Optional Feature:
Macro ADD_ACC_SATURATE_EN.
- Defined: on a capture edge with adder_overflow=1, acc loads +max (0111 for WIDTH=4) if adder_a MSB is 0, else -min (1000). Sticky overflow is still set.
- Undefined: acc always loads adder_sum (wrap).

Decomposition:
- Shared package/header holds:
  - State encoding constants (IDLE=2'd0, ACCEPT=2'd1, SETTLE=2'd2, DONE=2'd3).
  - Default WIDTH/CNT_WIDTH.
  - Saturation constants.
- One natural sub-module: add_settle_timer.
  - Loadable down-counter with load and done outputs.
  - Reused wherever gate-delayed structural logic is sampled.
- Top module holds the FSM, accumulator and flags.

Test Plan:
- Reset: hold rst_n=0, then release -> all outputs 0, state IDLE, start ignored for 0 cycles (accepted next edge).
- start, num_terms=3, operands 1,2,3 with in_valid held high -> out_valid after 18 clocks; out_result=0110, out_overflow=0, out_carry_count=0.
- num_terms=2, operands 0111, 0001 -> out_result=1000, out_overflow=1, out_carry_count=0. With ADD_ACC_SATURATE_EN: out_result=0111.
- num_terms=2, operands 1111, 1111 -> out_result=1110, out_overflow=0, out_carry_count=1.
- num_terms=0 -> out_valid next clock, out_result=0. Hold out_ready=0 for 10 clocks -> all outputs stable, busy=1.
- Drop rst_n mid-SETTLE of term 2 -> all outputs 0 asynchronously. A fresh start with num_terms=1, operand 0101 gives out_result=0101 with no stale flags.
